// File: rtl/disp_chan_sequencer.sv
// Channel-select and channel-0 load controller for the 8-channel display multiplexer.
// Manual or auto-scan channel selection plus a 4-phase CPU load handshake.
module disp_chan_sequencer #(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       auto_mode,
    input  logic [2:0] sw_sel,
    input  logic [7:0] chan_mask,
    input  logic       freeze,
    input  logic       cpu_req,
    output logic       cpu_ack,
    output logic [2:0] test_sel,
    output logic       disp_en,
    output logic       scan_tick
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACK  = 2'd2,
        ST_WAIT = 2'd3
    } hs_state_e;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    hs_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       test_sel_q, test_sel_d;
    logic             disp_en_q, disp_en_d;
    logic             cpu_ack_q, cpu_ack_d;
    logic             scan_tick_q, scan_tick_d;

    // Circular search for the next enabled channel after cur; returns cur if none other.
    function automatic logic [2:0] next_chan(input logic [2:0] cur, input logic [7:0] mask);
        logic [2:0] idx;
        logic       found;
        next_chan = cur;
        found     = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = cur + i[2:0];
            if (!found && mask[idx]) begin
                next_chan = idx;
                found     = 1'b1;
            end else begin
                found = found;
            end
        end
    endfunction

    // Channel selection and dwell counting.
    always_comb begin
        test_sel_d  = test_sel_q;
        cnt_d       = cnt_q;
        scan_tick_d = 1'b0;
        if (!auto_mode) begin
            test_sel_d = sw_sel;
            cnt_d      = '0;
        end else if (chan_mask == 8'h00) begin
            test_sel_d = 3'd0;
            cnt_d      = '0;
        end else if (!chan_mask[test_sel_q]) begin
            // Displayed channel was dropped from the mask: move on at once, even if frozen.
            test_sel_d = next_chan(test_sel_q, chan_mask);
            cnt_d      = '0;
        end else if (freeze) begin
            cnt_d = cnt_q;
        end else if (cnt_q == DWELL_LAST) begin
            test_sel_d  = next_chan(test_sel_q, chan_mask);
            cnt_d       = '0;
            scan_tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Handshake next-state; disp_en/cpu_ack are registered decodes of the next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: state_d = ST_ACK;
            ST_ACK:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (!cpu_req) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        disp_en_d = (state_d == ST_LOAD);
        cpu_ack_d = (state_d == ST_ACK);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            test_sel_q  <= 3'd0;
            disp_en_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            scan_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            test_sel_q  <= test_sel_d;
            disp_en_q   <= disp_en_d;
            cpu_ack_q   <= cpu_ack_d;
            scan_tick_q <= scan_tick_d;
        end
    end

    assign test_sel  = test_sel_q;
    assign disp_en   = disp_en_q;
    assign cpu_ack   = cpu_ack_q;
    assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_disp_chan_sequencer.sv
// Directed self-checking bench for disp_chan_sequencer with a 4-cycle dwell.
module tb_disp_chan_sequencer;

    logic       clk;
    logic       rst;
    logic       auto_mode;
    logic [2:0] sw_sel;
    logic [7:0] chan_mask;
    logic       freeze;
    logic       cpu_req;
    logic       cpu_ack;
    logic [2:0] test_sel;
    logic       disp_en;
    logic       scan_tick;

    int checks = 0;
    int errors = 0;
    int pulses;
    logic [2:0] exp_seq [3];

    disp_chan_sequencer #(.DWELL_CYCLES(4), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .auto_mode (auto_mode),
        .sw_sel    (sw_sel),
        .chan_mask (chan_mask),
        .freeze    (freeze),
        .cpu_req   (cpu_req),
        .cpu_ack   (cpu_ack),
        .test_sel  (test_sel),
        .disp_en   (disp_en),
        .scan_tick (scan_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; auto_mode = 1'b1; sw_sel = 3'd7; chan_mask = 8'hFF;
        freeze = 1'b1; cpu_req = 1'b1;
        step(2);
        chk("rst_test_sel", {5'd0, test_sel}, 8'd0);
        chk("rst_disp_en", {7'd0, disp_en}, 8'd0);
        chk("rst_cpu_ack", {7'd0, cpu_ack}, 8'd0);
        chk("rst_scan_tick", {7'd0, scan_tick}, 8'd0);

        // Manual selection
        rst = 1'b0; auto_mode = 1'b0; freeze = 1'b0; cpu_req = 1'b0; sw_sel = 3'd5;
        step(1);
        chk("man_sel5", {5'd0, test_sel}, 8'd5);
        chk("man_no_en", {7'd0, disp_en}, 8'd0);
        sw_sel = 3'd2;
        step(1);
        chk("man_sel2", {5'd0, test_sel}, 8'd2);
        sw_sel = 3'd0;
        step(1);
        chk("man_sel0", {5'd0, test_sel}, 8'd0);

        // Auto scan over mask 1000_0101 starting at channel 0
        auto_mode = 1'b1; chan_mask = 8'h85;
        exp_seq[0] = 3'd2; exp_seq[1] = 3'd7; exp_seq[2] = 3'd0;
        for (int k = 0; k < 3; k++) begin
            pulses = 0;
            for (int j = 0; j < 3; j++) begin
                step(1);
                if (scan_tick) pulses++;
                chk("scan_hold", {5'd0, test_sel}, (k == 0) ? 8'd0 : {5'd0, exp_seq[k-1]});
            end
            chk("scan_hold_tick", pulses[7:0], 8'd0);
            step(1);
            chk("scan_next", {5'd0, test_sel}, {5'd0, exp_seq[k]});
            chk("scan_tick", {7'd0, scan_tick}, 8'd1);
        end

        // Freeze mid-dwell
        step(2);
        freeze = 1'b1;
        pulses = 0;
        for (int j = 0; j < 10; j++) begin
            step(1);
            if (scan_tick) pulses++;
            chk("frz_hold", {5'd0, test_sel}, 8'd0);
        end
        chk("frz_no_tick", pulses[7:0], 8'd0);
        freeze = 1'b0;
        step(1);
        chk("frz_resume1", {5'd0, test_sel}, 8'd0);
        chk("frz_resume1_tick", {7'd0, scan_tick}, 8'd0);
        step(1);
        chk("frz_resume2", {5'd0, test_sel}, 8'd2);
        chk("frz_resume2_tick", {7'd0, scan_tick}, 8'd1);

        // Mask change drops the current channel
        chan_mask = 8'h05;
        step(1);
        chk("mask05_hold", {5'd0, test_sel}, 8'd2);
        chan_mask = 8'h81;
        step(1);
        chk("mask81_jump", {5'd0, test_sel}, 8'd7);
        chk("mask81_no_tick", {7'd0, scan_tick}, 8'd0);
        for (int j = 0; j < 3; j++) begin
            step(1);
            chk("mask81_dwell", {5'd0, test_sel}, 8'd7);
        end
        step(1);
        chk("mask81_wrap", {5'd0, test_sel}, 8'd0);
        chk("mask81_wrap_tick", {7'd0, scan_tick}, 8'd1);
        step(4);
        chk("mask81_to7", {5'd0, test_sel}, 8'd7);
        chan_mask = 8'h00;
        pulses = 0;
        for (int j = 0; j < 10; j++) begin
            step(1);
            if (scan_tick) pulses++;
            chk("mask0_sel", {5'd0, test_sel}, 8'd0);
        end
        chk("mask0_no_tick", pulses[7:0], 8'd0);

        // Handshake with level-high request while channel 3 is shown
        auto_mode = 1'b0; sw_sel = 3'd3; cpu_req = 1'b1;
        step(1);
        chk("hs_en", {7'd0, disp_en}, 8'd1);
        chk("hs_en_noack", {7'd0, cpu_ack}, 8'd0);
        chk("hs_sel3", {5'd0, test_sel}, 8'd3);
        step(1);
        chk("hs_ack", {7'd0, cpu_ack}, 8'd1);
        chk("hs_ack_noen", {7'd0, disp_en}, 8'd0);
        pulses = 0;
        for (int j = 0; j < 18; j++) begin
            step(1);
            if (disp_en || cpu_ack) pulses++;
        end
        chk("hs_single_pulse", pulses[7:0], 8'd0);
        cpu_req = 1'b0;
        step(1);
        chk("hs_idle_en", {7'd0, disp_en}, 8'd0);
        cpu_req = 1'b1;
        step(1);
        chk("hs2_en", {7'd0, disp_en}, 8'd1);
        step(1);
        chk("hs2_ack", {7'd0, cpu_ack}, 8'd1);
        cpu_req = 1'b0;
        step(2);

        // Reset while in LOAD
        cpu_req = 1'b1;
        step(1);
        chk("rl_en", {7'd0, disp_en}, 8'd1);
        rst = 1'b1; cpu_req = 1'b0;
        step(1);
        chk("rl_no_ack", {7'd0, cpu_ack}, 8'd0);
        chk("rl_no_en", {7'd0, disp_en}, 8'd0);
        rst = 1'b0;
        step(1);
        chk("rl_idle_ack", {7'd0, cpu_ack}, 8'd0);
        chk("rl_idle_en", {7'd0, disp_en}, 8'd0);
        cpu_req = 1'b1;
        step(1);
        chk("rl_new_en", {7'd0, disp_en}, 8'd1);
        step(1);
        chk("rl_new_ack", {7'd0, cpu_ack}, 8'd1);
        cpu_req = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
